td_delay_chain: RTL and testbench
=================================

Name: td_delay_chain

Overview:
- Synchronous, parametrised successor to the fixed five-tap analogue delay-line part.
- Provides a WIDTH-channel tapped delay line with TAPS taps spaced SPACING enabled clocks apart.
- Offers a selectable inertial mode that swallows input pulses shorter than MIN_PULSE samples.
- Used where CADR timing chains need clocked, synthesizable delays with edge-event and in-flight status.

Parameters:
- TAPS, 5, number of output taps (>=1)
- SPACING, 2, enabled clocks between successive taps (>=1)
- WIDTH, 1, independent channels (>=1)
- MIN_PULSE, 2, inertial mode: consecutive enabled samples din must differ before it is accepted (>=1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- en  in  1  advance enable; low = all state except prev holds
- mode  in  1  0 = transport, 1 = inertial
- din  in  WIDTH  channel inputs
- taps  out  TAPS*WIDTH  tap k (1..TAPS), channel c at bit (k-1)*WIDTH+c
- rise  out  WIDTH  one-clk pulse, final tap went 0->1
- fall  out  WIDTH  one-clk pulse, final tap went 1->0
- busy  out  1  a transition is in flight in any channel

Behaviour:
- State per channel:
  - sr[0..L-1], where L = TAPS*SPACING
  - filter bit f
  - counter cnt, width clog2(MIN_PULSE+1)
  - prev (copy of final tap)
- Reset:
  - reset_n low at a clk edge clears sr, f, cnt and prev to 0.
  - Reset overrides en.
  - After reset, taps = 0, rise = fall = 0, busy = 0.
  - Reset mid-flight discards all in-flight transitions with no rise/fall pulse.
- Enabled edge, en=1:
  - Transport mode: f <= din, cnt <= 0, sr[0] <= din.
  - Inertial mode, din == f: cnt <= 0.
  - Inertial mode, din != f and cnt == MIN_PULSE-1: f <= din, cnt <= 0.
  - Inertial mode, din != f otherwise: cnt <= cnt+1.
  - Inertial mode: sr[0] <= f (old value).
  - Both modes: sr[i] <= sr[i-1] for i = 1..L-1.
- en=0: sr, f and cnt hold; prev still updates.
- Taps: tap k = sr[k*SPACING-1]. Outputs are registered, no combinational path from din.
- Latency, counted in enabled edges with E0 = first edge sampling the new din value:
  - Transport: tap k changes at edge E(k*SPACING-1).
  - Inertial: din must hold for edges E0..E(MIN_PULSE-1); tap k changes at E(MIN_PULSE-1+k*SPACING).
  - A shorter inertial pulse never reaches sr.
  - Accepted pulse widths are preserved exactly.
- Mode switch:
  - Allowed at any cycle; sr contents are kept.
  - f tracks din in transport mode, so switching to inertial is glitch-free.
  - On the first inertial edge after a switch, sr[0] takes f, which equals the previous din.
- Edge events:
  - prev <= sr[L-1] on every clk edge, independent of en.
  - rise = sr[L-1] & ~prev; fall = ~sr[L-1] & prev.
  - Each is high for exactly one clk after the final tap changes.
- busy = OR over channels of (cnt != 0 or any sr bit != f).
  - Registered-only logic; goes low the clk after the final tap settles.
- Channels are fully independent; no cross-channel interaction.
- Elaboration error if any parameter is < 1.

Test Plan:
1. Defaults, mode=0, en=1, din 0->1 sampled at E0 and held -> tap1..tap5 rise after E1, E3, E5, E7, E9; rise=1 for one clk after E9; busy high after E0, low after E9.
2. mode=1, MIN_PULSE=2, din=1 only at E0 -> no tap moves, rise/fall never pulse; busy high one clk (cnt=1), then low.
3. mode=1, MIN_PULSE=2, din=1 at E0 and E1, then 0 -> tap5 high after E11 and E12, low after E13; rise after E11, fall after E13.
4. mode=0, en dropped for 4 clks after E3 during a 0->1 transition -> tap5 rises 4 clks later than in test 1; pulse width unchanged; taps frozen while en=0.
5. reset_n low for one edge while taps = 5'b00111 and din=1 -> taps=0, busy=0, no fall pulse; after release, din=1 propagates with test-1 timing.
6. WIDTH=4, only din[2] pulses 3 cycles in transport mode -> only bits (k-1)*4+2 toggle; rise[2] and fall[2] pulse; all other channels stay 0.

Source files
------------

// File: rtl/td_delay_chain.sv
// Clocked, parametrised tapped delay line with optional inertial (pulse-swallowing)
// input filter, final-tap edge events and an in-flight status flag.
module td_delay_chain #(
  parameter int TAPS      = 5,
  parameter int SPACING   = 2,
  parameter int WIDTH     = 1,
  parameter int MIN_PULSE = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      din,
  output logic [TAPS*WIDTH-1:0] taps,
  output logic [WIDTH-1:0]      rise,
  output logic [WIDTH-1:0]      fall,
  output logic                  busy
);

  localparam int L  = TAPS * SPACING;
  localparam int CW = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MIN_PULSE - 1);

  if (TAPS < 1)      begin : g_bad_taps    $error("td_delay_chain: TAPS must be >= 1");      end
  if (SPACING < 1)   begin : g_bad_spacing $error("td_delay_chain: SPACING must be >= 1");   end
  if (WIDTH < 1)     begin : g_bad_width   $error("td_delay_chain: WIDTH must be >= 1");     end
  if (MIN_PULSE < 1) begin : g_bad_minp    $error("td_delay_chain: MIN_PULSE must be >= 1"); end

  logic [WIDTH-1:0] busy_ch;

  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    logic [L-1:0]  sr;
    logic [L-1:0]  sr_nxt;
    logic          f;
    logic          f_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          prev;

    // In transport mode f shadows din so that a later switch to inertial
    // starts from the current level and cannot inject a spurious edge.
    always_comb begin
      f_nxt   = f;
      cnt_nxt = cnt;
      sr_nxt  = sr;
      if (!mode) begin
        f_nxt     = din[c];
        cnt_nxt   = '0;
        sr_nxt[0] = din[c];
      end else begin
        sr_nxt[0] = f;
        if (din[c] == f) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          f_nxt   = din[c];
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      for (int i = 1; i < L; i++) begin
        sr_nxt[i] = sr[i-1];
      end
    end

    // prev runs on every edge so the edge pulses last one clock even when en drops.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        sr   <= '0;
        f    <= 1'b0;
        cnt  <= '0;
        prev <= 1'b0;
      end else begin
        prev <= sr[L-1];
        if (en) begin
          sr  <= sr_nxt;
          f   <= f_nxt;
          cnt <= cnt_nxt;
        end
      end
    end

    for (genvar k = 1; k <= TAPS; k++) begin : g_tap
      assign taps[(k-1)*WIDTH+c] = sr[k*SPACING-1];
    end

    assign rise[c]    = sr[L-1] & ~prev;
    assign fall[c]    = ~sr[L-1] & prev;
    assign busy_ch[c] = (cnt != '0) | (sr != {L{f}});
  end

  assign busy = |busy_ch;

endmodule

// File: tb/tb_td_delay_chain.sv
// Randomised + directed bench for td_delay_chain: a stream/window reference model
// pushes expected outputs into a queue; a negedge monitor pops and compares.
module tb_td_delay_chain;

  localparam int TAPS = 5;
  localparam int SP   = 2;
  localparam int W    = 4;
  localparam int MP   = 2;
  localparam int L    = TAPS * SP;

  logic              clk;
  logic              reset_n;
  logic              en;
  logic              mode;
  logic [W-1:0]      din;
  logic [TAPS*W-1:0] taps;
  logic [W-1:0]      rise;
  logic [W-1:0]      fall;
  logic              busy;

  td_delay_chain #(.TAPS(TAPS), .SPACING(SP), .WIDTH(W), .MIN_PULSE(MP)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .taps   (taps),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TAPS*W-1:0] taps;
    logic [W-1:0]      rise;
    logic [W-1:0]      fall;
    logic              busy;
  } exp_t;

  typedef struct {
    logic [W-1:0] d;
    logic         m;
  } samp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: m_stream[j] is the value that entered the line j enabled
  // edges ago (missing entries are zero); m_hist holds the latest enabled samples.
  logic [W-1:0] m_stream[$];
  samp_t        m_hist[$];
  logic [W-1:0] m_f;
  logic [W-1:0] m_cntnz;
  logic [W-1:0] m_prev;

  function automatic logic [W-1:0] sr_at(input int j);
    if (j < m_stream.size()) return m_stream[j];
    return '0;
  endfunction

  task automatic model_edge(input logic rn, input logic e, input logic md, input logic [W-1:0] d);
    logic [W-1:0] fnew;
    logic [W-1:0] fin;
    samp_t        s;
    exp_t         x;
    bit           acc;
    if (!rn) begin
      m_stream.delete();
      m_hist.delete();
      m_f     = '0;
      m_cntnz = '0;
      m_prev  = '0;
    end else begin
      m_prev = sr_at(L-1);
      if (e) begin
        s.d = d;
        s.m = md;
        m_hist.push_front(s);
        if (m_hist.size() > MP) void'(m_hist.pop_back());
        fnew = m_f;
        for (int c = 0; c < W; c++) begin
          if (!md) begin
            fnew[c] = d[c];
          end else begin
            // accept only after MP consecutive inertial samples all opposite to f
            acc = (m_hist.size() == MP);
            for (int i = 0; i < m_hist.size(); i++)
              if (!m_hist[i].m || m_hist[i].d[c] == m_f[c]) acc = 0;
            if (acc) fnew[c] = d[c];
          end
        end
        m_stream.push_front(md ? m_f : d);
        if (m_stream.size() > L) void'(m_stream.pop_back());
        m_cntnz = md ? (d ^ fnew) : '0;
        m_f     = fnew;
      end
    end
    for (int k = 1; k <= TAPS; k++) x.taps[(k-1)*W +: W] = sr_at(k*SP-1);
    fin    = sr_at(L-1);
    x.rise = fin & ~m_prev;
    x.fall = ~fin & m_prev;
    x.busy = |m_cntnz;
    for (int j = 0; j < L; j++)
      if ((sr_at(j) ^ m_f) != '0) x.busy = 1'b1;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic rn, input logic e, input logic md, input logic [W-1:0] d);
    reset_n = rn;
    en      = e;
    mode    = md;
    din     = d;
    @(posedge clk);
    #1;
    model_edge(rn, e, md, d);
  endtask

  task automatic hold(input int n, input logic md, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, md, d);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("taps", 64'(taps), 64'(e.taps));
      chk("rise", 64'(rise), 64'(e.rise));
      chk("fall", 64'(fall), 64'(e.fall));
      chk("busy", 64'(busy), 64'(e.busy));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : drv
    logic [W-1:0] d;
    logic         md;
    logic         e;
    logic         rn;
    reset_n = 1'b0;
    en      = 1'b0;
    mode    = 1'b0;
    din     = '0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);

    // transport 0->1 propagation through all taps
    hold(2, 1'b0, 4'b0000);
    hold(14, 1'b0, 4'b0001);
    hold(14, 1'b0, 4'b0000);
    // inertial: single-sample pulse swallowed
    hold(3, 1'b1, 4'b0000);
    hold(1, 1'b1, 4'b0001);
    hold(14, 1'b1, 4'b0000);
    // inertial: two-sample pulse accepted, width preserved
    hold(2, 1'b1, 4'b0001);
    hold(16, 1'b1, 4'b0000);
    // transport with en dropped for 4 clocks mid-flight
    hold(4, 1'b0, 4'b0001);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 4'b0001);
    hold(12, 1'b0, 4'b0001);
    hold(16, 1'b0, 4'b0000);
    // reset while taps partially filled, then re-propagate
    hold(6, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    hold(14, 1'b0, 4'b0001);
    hold(14, 1'b0, 4'b0000);
    // single channel pulse, others quiet
    hold(3, 1'b0, 4'b0100);
    hold(14, 1'b0, 4'b0000);

    d  = '0;
    md = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(3) == 0) d[c] = ~d[c];
      if ($urandom_range(39) == 0) md = ~md;
      e  = ($urandom_range(7) != 0);
      rn = ($urandom_range(199) != 0);
      step(rn, e, md, d);
    end
    hold(L + 4, md, '0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
